// File: rtl/aec_pkg.sv
// Shared types and constants for the AEC job scheduler.
package aec_pkg;

  localparam logic [7:0] ASCII_EQ = 8'd61;
  localparam logic [7:0] ASCII_LP = 8'd40;
  localparam logic [7:0] ASCII_RP = 8'd41;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    WAIT,
    GAP
  } sched_state_t;

  typedef logic [1:0] err_t;
  localparam err_t ERR_OK  = 2'b00;
  localparam err_t ERR_OVF = 2'b01;
  localparam err_t ERR_TO  = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, with wrap-around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    any   = |req;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/aec_job_scheduler.sv
// Time-shares one expression calculator among NUM_REQ character sources, with
// overflow and hung-evaluation protection.
//
// state  | meaning
// IDLE   | arbitrate among requesting sources
// STREAM | forward the winner's characters to the calculator
// DRAIN  | overflowed: discard source chars until its '=' or req drop
// WAIT   | wait for the calculator result or timeout
// GAP    | one settle cycle before the next arbitration
module aec_job_scheduler
  import aec_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_ascii,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 aec_ready,
  output logic [7:0]           aec_ascii,
  output logic                 aec_soft_rst,
  input  logic                 aec_valid,
  input  logic [6:0]           aec_result,
  input  logic                 aec_legal,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [6:0]           rsp_result,
  output logic                 rsp_legal,
  output logic [1:0]           rsp_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] LEN_TC = CW'(MAX_LEN);
  localparam logic [7:0]    TO_TC  = 8'(TIMEOUT);
  localparam logic [IW-1:0] LAST   = IW'(NUM_REQ - 1);

  sched_state_t state, state_d;
  logic [IW-1:0] winner, winner_d, rr_ptr, rr_ptr_d;
  logic [CW-1:0] char_cnt, char_cnt_d;
  logic [7:0]    to_cnt, to_cnt_d;
  err_t          err, err_d;

  logic [NUM_REQ-1:0] gnt_d;
  logic               ready_d, soft_rst_d, rsp_valid_d, rsp_legal_d;
  logic [7:0]         ascii_d;
  logic [2:0]         rsp_id_d;
  logic [6:0]         rsp_result_d;
  logic [1:0]         rsp_err_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  logic [7:0] src_char [NUM_REQ];
  logic [7:0] cur_char;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign src_char[i] = req_ascii[8*i +: 8];
  end
  assign cur_char = src_char[winner];

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_d      = state;
    winner_d     = winner;
    rr_ptr_d     = rr_ptr;
    char_cnt_d   = char_cnt;
    to_cnt_d     = to_cnt;
    err_d        = err;
    gnt_d        = gnt;
    ready_d      = 1'b0;
    ascii_d      = 8'd0;
    soft_rst_d   = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id;
    rsp_result_d = rsp_result;
    rsp_legal_d  = rsp_legal;
    rsp_err_d    = rsp_err;

    case (state)
      IDLE: begin
        if (arb_any) begin
          gnt_d      = arb_gnt;
          winner_d   = arb_idx;
          err_d      = ERR_OK;
          char_cnt_d = '0;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        ready_d = (char_cnt == '0);
        if (cur_char == ASCII_EQ) begin
          ascii_d    = ASCII_EQ;
          gnt_d      = '0;
          char_cnt_d = '0;
          to_cnt_d   = 8'd1;
          state_d    = WAIT;
        end else if (char_cnt == LEN_TC) begin
          // buffer full: terminate the expression ourselves
          ascii_d    = ASCII_EQ;
          err_d      = ERR_OVF;
          gnt_d      = '0;
          char_cnt_d = '0;
          state_d    = DRAIN;
        end else begin
          ascii_d    = cur_char;
          char_cnt_d = char_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cur_char == ASCII_EQ || !req[winner]) begin
          to_cnt_d = 8'd1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // a result arriving on the terminal-count cycle still wins
        if (aec_valid) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = 3'(winner);
          rsp_err_d    = err;
          rsp_result_d = (err == ERR_OVF) ? 7'd0 : aec_result;
          rsp_legal_d  = (err == ERR_OVF) ? 1'b0 : aec_legal;
          rr_ptr_d     = (winner == LAST) ? '0 : winner + 1'b1;
          state_d      = GAP;
        end else if (to_cnt == TO_TC) begin
          soft_rst_d   = 1'b1;
          rsp_valid_d  = 1'b1;
          rsp_id_d     = 3'(winner);
          rsp_err_d    = ERR_TO;
          rsp_result_d = 7'd0;
          rsp_legal_d  = 1'b0;
          rr_ptr_d     = (winner == LAST) ? '0 : winner + 1'b1;
          state_d      = GAP;
        end else begin
          to_cnt_d = to_cnt + 8'd1;
        end
      end
      GAP: begin
        to_cnt_d = 8'd0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      winner       <= '0;
      rr_ptr       <= '0;
      char_cnt     <= '0;
      to_cnt       <= 8'd0;
      err          <= ERR_OK;
      gnt          <= '0;
      aec_ready    <= 1'b0;
      aec_ascii    <= 8'd0;
      aec_soft_rst <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 3'd0;
      rsp_result   <= 7'd0;
      rsp_legal    <= 1'b0;
      rsp_err      <= 2'b00;
    end else begin
      state        <= state_d;
      winner       <= winner_d;
      rr_ptr       <= rr_ptr_d;
      char_cnt     <= char_cnt_d;
      to_cnt       <= to_cnt_d;
      err          <= err_d;
      gnt          <= gnt_d;
      aec_ready    <= ready_d;
      aec_ascii    <= ascii_d;
      aec_soft_rst <= soft_rst_d;
      rsp_valid    <= rsp_valid_d;
      rsp_id       <= rsp_id_d;
      rsp_result   <= rsp_result_d;
      rsp_legal    <= rsp_legal_d;
      rsp_err      <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_aec_job_scheduler.sv
// Directed bench for aec_job_scheduler; the bench plays both the sources and the calculator.
module tb_aec_job_scheduler;
  import aec_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 255;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_ascii;
  logic [NUM_REQ-1:0]   gnt;
  logic                 aec_ready;
  logic [7:0]           aec_ascii;
  logic                 aec_soft_rst;
  logic                 aec_valid;
  logic [6:0]           aec_result;
  logic                 aec_legal;
  logic                 rsp_valid;
  logic [2:0]           rsp_id;
  logic [6:0]           rsp_result;
  logic                 rsp_legal;
  logic [1:0]           rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aec_job_scheduler #(.NUM_REQ(NUM_REQ), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_ascii    (req_ascii),
    .gnt          (gnt),
    .aec_ready    (aec_ready),
    .aec_ascii    (aec_ascii),
    .aec_soft_rst (aec_soft_rst),
    .aec_valid    (aec_valid),
    .aec_result   (aec_result),
    .aec_legal    (aec_legal),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_legal    (rsp_legal),
    .rsp_err      (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic wait_gnt(input int id);
    int n = 0;
    while (!gnt[id] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("gnt_src%0d", id), 32'(gnt), 32'(1 << id));
  endtask

  // Source id streams s starting in the cycle its grant is visible.
  task automatic stream(input int id, input string s);
    logic [7:0] want;
    for (int k = 0; k < s.len(); k++) begin
      req_ascii[8*id +: 8] = s[k];
      @(negedge clk);
      if (k < MAX_LEN)       want = s[k];
      else if (k == MAX_LEN) want = ASCII_EQ;
      else                   want = 8'd0;
      check($sformatf("ascii_src%0d_k%0d", id, k), 32'(aec_ascii), 32'(want));
      check($sformatf("ready_src%0d_k%0d", id, k), 32'(aec_ready), (k == 0) ? 32'd1 : 32'd0);
    end
    check($sformatf("gnt_drop_src%0d", id), 32'(gnt), 32'd0);
    req_ascii[8*id +: 8] = 8'd0;
    req[id] = 1'b0;
  endtask

  task automatic respond(input int delay, input logic [6:0] res, input logic leg);
    repeat (delay) @(negedge clk);
    aec_valid  = 1'b1;
    aec_result = res;
    aec_legal  = leg;
    @(negedge clk);
    aec_valid  = 1'b0;
    aec_result = 7'd0;
    aec_legal  = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input int id, input int res, input int leg, input int err);
    check({tag, "_valid"},  32'(rsp_valid),  32'd1);
    check({tag, "_id"},     32'(rsp_id),     32'(id));
    check({tag, "_result"}, 32'(rsp_result), 32'(res));
    check({tag, "_legal"},  32'(rsp_legal),  32'(leg));
    check({tag, "_err"},    32'(rsp_err),    32'(err));
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int n;
    int id;
    string s3;

    rst        = 1'b1;
    req        = '0;
    req_ascii  = '0;
    aec_valid  = 1'b0;
    aec_result = 7'd0;
    aec_legal  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt",    32'(gnt),          32'd0);
    check("rst_ready",  32'(aec_ready),    32'd0);
    check("rst_ascii",  32'(aec_ascii),    32'd0);
    check("rst_softrst",32'(aec_soft_rst), 32'd0);
    check("rst_rspv",   32'(rsp_valid),    32'd0);
    check("rst_rspres", 32'(rsp_result),   32'd0);
    check("rst_rsperr", 32'(rsp_err),      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single source, "(1+2)*3=" -> 9
    req[0] = 1'b1;
    wait_gnt(0);
    stream(0, "(1+2)*3=");
    respond(3, 7'd9, 1'b1);
    check_rsp("t1", 0, 9, 1, 0);
    @(negedge clk);
    check("t1_rspv_pulse", 32'(rsp_valid), 32'd0);

    // 2: all four request, round-robin from pointer 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (gnt == '0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("t2_gnt_%0d", g), 32'(gnt), 32'(1 << order[g]));
      id = -1;
      for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) id = i;
      if (id >= 0) stream(id, "1+1=");
      respond(2, 7'd2, 1'b1);
      check_rsp($sformatf("t2_rsp_%0d", g), order[g], 2, 1, 0);
      if (g == 0) req[0] = 1'b1;
    end
    req = '0;
    @(negedge clk);

    // 3: source 2 overflows with 17 digits, then its own '=' is drained
    s3 = "";
    for (int i = 0; i < 17; i++) s3 = {s3, "1"};
    s3 = {s3, "="};
    req[2] = 1'b1;
    wait_gnt(2);
    stream(2, s3);
    respond(2, 7'd5, 1'b1);
    check_rsp("t3", 2, 0, 0, 1);
    @(negedge clk);

    // 4: calculator silent -> soft reset TIMEOUT cycles after '='
    req[3] = 1'b1;
    wait_gnt(3);
    stream(3, "1=");
    n = 0;
    while (!aec_soft_rst && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_to_cycles", 32'(n), 32'(TIMEOUT));
    check_rsp("t4", 3, 0, 0, 2);
    @(negedge clk);
    check("t4_softrst_pulse", 32'(aec_soft_rst), 32'd0);

    // 5: unbalanced parentheses after a timeout
    req[1] = 1'b1;
    wait_gnt(1);
    stream(1, "(1+2=");
    respond(1, 7'd0, 1'b0);
    check_rsp("t5", 1, 0, 0, 0);
    @(negedge clk);

    // 6: reset during STREAM, then arbitration restarts from pointer 0
    req[0] = 1'b1;
    wait_gnt(0);
    req_ascii[7:0] = "(";
    @(negedge clk);
    check("t6_ready_pre", 32'(aec_ready), 32'd1);
    req_ascii[7:0] = "1";
    rst = 1'b1;
    #1;
    check("t6_gnt",   32'(gnt),       32'd0);
    check("t6_ready", 32'(aec_ready), 32'd0);
    check("t6_ascii", 32'(aec_ascii), 32'd0);
    check("t6_rspv",  32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_ascii = '0;
    req = 4'b1010;
    rst = 1'b0;
    wait_gnt(1);
    stream(1, "1=");
    respond(1, 7'd1, 1'b1);
    check_rsp("t6", 1, 1, 1, 0);
    req = '0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
